// File: rtl/de0_lt24_event_capture.sv
// Avalon-MM event timestamp peripheral: captures a timer-tick epoch count into a FIFO on event_in edges.
// Optional input glitch filter enabled by defining EVENT_CAPTURE_FILTER_EN.
module de0_lt24_event_capture #(
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        timer_tick,
  input  logic        event_in,
  output logic        irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic        tick_q, tick_q2, tick_rise;
  logic [31:0] tick_count;
  logic [15:0] tick_shadow;
  logic        ev_sync1, ev_sync2, ev_level, ev_prev, ev_rise;
  logic        irq_en, capture_en, overflow;
  logic [31:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic        rd_strobe, wr_strobe, flush, clr_ticks;
  logic        fifo_empty, fifo_full, pop_req, push_req, do_pop, do_push, ovf_set;
  logic [31:0] head;
  logic [15:0] status_word;
  logic        unused_writedata;

  assign unused_writedata = ^writedata[15:4];

  assign rd_strobe  = chipselect && !read_n;
  assign wr_strobe  = chipselect && !write_n;
  assign flush      = wr_strobe && (address == 3'd1) && writedata[2];
  assign clr_ticks  = wr_strobe && (address == 3'd1) && writedata[3];
  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
  assign pop_req    = rd_strobe && (address == 3'd5);
  assign push_req   = capture_en && ev_rise;
  assign do_pop     = pop_req && !fifo_empty && !flush;
  assign do_push    = push_req && (!fifo_full || do_pop) && !flush;
  assign ovf_set    = push_req && fifo_full && !pop_req && !flush;
  assign head       = fifo_empty ? 32'h0 : mem[rd_ptr];
  assign tick_rise  = tick_q && !tick_q2;
  assign ev_rise    = ev_level && !ev_prev;
  assign status_word = {7'd0, 5'(level), 1'b0, overflow, fifo_full, !fifo_empty};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q     <= 1'b0;
      tick_q2    <= 1'b0;
      tick_count <= '0;
    end else begin
      tick_q  <= timer_tick;
      tick_q2 <= tick_q;
      if (clr_ticks)
        tick_count <= '0;
      else if (tick_rise)
        tick_count <= tick_count + 32'd1;
    end
  end

  // Sync and edge flops reset high so a line already high at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_sync1 <= 1'b1;
      ev_sync2 <= 1'b1;
      ev_prev  <= 1'b1;
    end else begin
      ev_sync1 <= event_in;
      ev_sync2 <= ev_sync1;
      ev_prev  <= ev_level;
    end
  end

`ifdef EVENT_CAPTURE_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILTER_LEN - 1);
  logic [CNT_W-1:0] filt_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_level <= 1'b1;
      filt_cnt <= CNT_LOAD;
    end else if (ev_sync2 == ev_level) begin
      filt_cnt <= CNT_LOAD;
    end else if (filt_cnt == '0) begin
      ev_level <= ev_sync2;
      filt_cnt <= CNT_LOAD;
    end else begin
      filt_cnt <= filt_cnt - 1'b1;
    end
  end
`else
  localparam int unused_filter_len = FILTER_LEN;
  assign ev_level = ev_sync2;
`endif

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= tick_count;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        if (do_push && !do_pop)
          level <= level + 1'b1;
        else if (do_pop && !do_push)
          level <= level - 1'b1;
      end
      // A new drop outranks a same-cycle clearing write.
      if (ovf_set)
        overflow <= 1'b1;
      else if (wr_strobe && (address == 3'd0))
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en      <= 1'b0;
      capture_en  <= 1'b0;
      tick_shadow <= '0;
      readdata    <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_strobe && (address == 3'd1)) begin
        irq_en     <= writedata[0];
        capture_en <= writedata[1];
      end
      if (rd_strobe && (address == 3'd2))
        tick_shadow <= tick_count[31:16];
      if (rd_strobe) begin
        case (address)
          3'd0:    readdata <= status_word;
          3'd1:    readdata <= {14'd0, capture_en, irq_en};
          3'd2:    readdata <= tick_count[15:0];
          3'd3:    readdata <= tick_shadow;
          3'd4:    readdata <= head[15:0];
          3'd5:    readdata <= head[31:16];
          default: readdata <= '0;
        endcase
      end
      irq <= irq_en && (!fifo_empty || overflow);
    end
  end

endmodule

// File: tb/tb_de0_lt24_event_capture.sv
// Self-checking bench for de0_lt24_event_capture against a queue-based timestamp model.
// Define EVENT_CAPTURE_FILTER_EN for both files to exercise the filtered build.
module tb_de0_lt24_event_capture;
  localparam int DEPTH = 8;
`ifdef EVENT_CAPTURE_FILTER_EN
  localparam int PUSH_EDGES = 7;
`else
  localparam int PUSH_EDGES = 3;
`endif

  logic        clk, reset_n, chipselect, read_n, write_n, timer_tick, event_in, irq;
  logic [2:0]  address;
  logic [15:0] writedata, readdata, d;

  int total = 0;
  int bad = 0;

  logic [31:0] model_q[$];
  logic [31:0] model_ticks;
  bit          model_ovf, model_irq_en, model_capture;

  de0_lt24_event_capture #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .timer_tick(timer_tick), .event_in(event_in), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] data);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    cycle();
    chipselect = 1'b0; read_n = 1'b1;
    data = readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] v);
    address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
    cycle();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  function automatic logic [15:0] status_exp();
    logic [15:0] s;
    int n;
    n = model_q.size();
    s = '0;
    s[8:4] = 5'(n);
    s[2] = model_ovf;
    s[1] = (n == DEPTH);
    s[0] = (n != 0);
    return s;
  endfunction

  function automatic logic irq_exp();
    return model_irq_en && ((model_q.size() != 0) || model_ovf);
  endfunction

  task automatic do_tick();
    timer_tick = 1'b1;
    repeat (2) cycle();
    timer_tick = 1'b0;
    repeat (2) cycle();
    model_ticks = model_ticks + 32'd1;
  endtask

  task automatic model_push();
    if (model_capture) begin
      if (model_q.size() < DEPTH) model_q.push_back(model_ticks);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic do_event();
    event_in = 1'b1;
    repeat (8) cycle();
    event_in = 1'b0;
    repeat (8) cycle();
    model_push();
  endtask

  task automatic check_status(input string tag);
    logic [15:0] s;
    rd(3'd0, s);
    check(tag, s, status_exp());
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] lo, hi;
    logic [31:0] e;
    e = (model_q.size() != 0) ? model_q.pop_front() : 32'h0;
    rd(3'd4, lo);
    rd(3'd5, hi);
    check({tag, "_lo"}, lo, e[15:0]);
    check({tag, "_hi"}, hi, e[31:16]);
    cycle();
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = '0; writedata = '0; timer_tick = 1'b0; event_in = 1'b0;
    model_ticks = '0; model_ovf = 0; model_irq_en = 0; model_capture = 0;
    repeat (3) cycle();
    check("reset_readdata", readdata, 0);
    check("reset_irq", irq, 0);
    reset_n = 1'b1;
    repeat (10) cycle();
    check_status("reset_status");
    rd(3'd1, d); check("reset_control", d, 0);
    rd(3'd2, d); check("reset_tick_l", d, 0);
    rd(3'd4, d); check("empty_fifo_l", d, 0);
    rd(3'd6, d); check("addr6", d, 0);
    rd(3'd7, d); check("addr7", d, 0);

    // basic capture
    wr(3'd1, 16'h0002); model_capture = 1;
    rd(3'd1, d); check("control_rb", d, 16'h0002);
    cycle();
    check("readdata_hold", readdata, 16'h0002);
    repeat (3) do_tick();
    do_event();
    rd(3'd4, d); check("basic_fifo_l", d, 16'h0003);
    rd(3'd5, d); check("basic_fifo_h", d, 16'h0000);
    void'(model_q.pop_front());
    check_status("basic_status");

    // overflow with randomized tick spacing
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 2)) do_tick();
      do_event();
    end
    check_status("ovf_status");
    wr(3'd0, 16'h0000); model_ovf = 0;
    check_status("ovf_cleared");

    // push aligned with pop while full
    event_in = 1'b1;
    repeat (PUSH_EDGES - 1) cycle();
    rd(3'd5, d);
    begin
      logic [31:0] f;
      f = model_q.pop_front();
      check("fullpp_pop_hi", d, f[31:16]);
      model_q.push_back(model_ticks);
    end
    repeat (8 - PUSH_EDGES) cycle();
    event_in = 1'b0;
    repeat (8) cycle();
    check_status("fullpp_status");
    for (int i = 0; i < DEPTH; i++) pop_check("drain");
    check_status("drained_status");

    // interrupt, clr_ticks, flush
    wr(3'd1, 16'h000B); model_irq_en = 1; model_ticks = '0;
    rd(3'd2, d); check("clr_ticks", d, 0);
    rd(3'd1, d); check("ctrl_selfclear", d, 16'h0003);
    cycle();
    event_in = 1'b1;
    repeat (PUSH_EDGES) cycle();
    check("irq_at_push", irq, 0);
    cycle();
    check("irq_after_push", irq, 1);
    repeat (8 - PUSH_EDGES - 1) cycle();
    event_in = 1'b0;
    repeat (8) cycle();
    model_push();
    rd(3'd4, d); check("irq_entry_lo", d, model_q[0][15:0]);
    rd(3'd5, d); void'(model_q.pop_front());
    check("irq_at_pop", irq, 1);
    cycle();
    check("irq_after_pop", irq, 0);
    event_in = 1'b1;
    repeat (PUSH_EDGES - 1) cycle();
    wr(3'd1, 16'h0007);
    repeat (8 - PUSH_EDGES) cycle();
    event_in = 1'b0;
    repeat (8) cycle();
    check_status("flush_push_status");
    check("flush_irq", irq, 0);

    // shadow and wrap
    force dut.tick_count = 32'hFFFF_FFFF;
    cycle();
    release dut.tick_count;
    model_ticks = 32'hFFFF_FFFF;
    rd(3'd2, d); check("wrap_tick_l", d, model_ticks[15:0]);
    do_tick();
    rd(3'd3, d); check("wrap_shadow", d, 16'hFFFF);
    rd(3'd2, d); check("wrap_live_l", d, model_ticks[15:0]);
    rd(3'd3, d); check("wrap_live_h", d, model_ticks[31:16]);

`ifdef EVENT_CAPTURE_FILTER_EN
    event_in = 1'b1; repeat (3) cycle();
    event_in = 1'b0; repeat (12) cycle();
    check_status("filter_short");
    do_tick();
    event_in = 1'b1; repeat (6) cycle();
    event_in = 1'b0; repeat (12) cycle();
    model_push();
    check_status("filter_long");
    pop_check("filter_pop");
`else
    do_tick();
    for (int k = 0; k < 2; k++) begin
      event_in = 1'b1; repeat (2) cycle();
      event_in = 1'b0; repeat (2) cycle();
      model_push();
    end
    repeat (4) cycle();
    check_status("min_pulse_status");
    pop_check("min_pulse_a");
    pop_check("min_pulse_b");
`endif

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: repeat ($urandom_range(1, 3)) do_tick();
        1: do_event();
        2: pop_check("rand_pop");
        3: begin wr(3'd0, 16'(($urandom))); model_ovf = 0; cycle(); end
        default: check_status("rand_status");
      endcase
      cycle();
      check("rand_irq", irq, irq_exp());
    end
    check_status("rand_final_status");

    // reset mid-operation with event_in high
    do_event();
    event_in = 1'b1;
    reset_n = 1'b0;
    #2;
    check("midreset_readdata", readdata, 0);
    check("midreset_irq", irq, 0);
    repeat (2) cycle();
    reset_n = 1'b1;
    model_q.delete(); model_ovf = 0; model_ticks = '0; model_irq_en = 0; model_capture = 0;
    repeat (4) cycle();
    check_status("post_reset_status");
    wr(3'd1, 16'h0003); model_irq_en = 1; model_capture = 1;
    repeat (15) cycle();
    check_status("no_spurious_push");
    check("no_spurious_irq", irq, 0);
    event_in = 1'b0;
    repeat (10) cycle();
    do_event();
    pop_check("post_reset_pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/de0_lt24_event_capture.md
# de0_lt24_event_capture

Avalon-MM slave peripheral that timestamps external sensor/encoder events against a 32-bit epoch counter clocked by the interval timer's periodic tick. It consumes the timer's `irq` level directly, so its timestamps are in timer periods. Events are queued in a small FIFO and drained by the Nios II over a 16-bit register interface. It raises its own interrupt while the queue is non-empty.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: queue entries; power of two, 2..16.
- `FILTER_LEN`, 4: cycles `event_in` must be stable to be accepted; used only when the filter is compiled in.

Ports:
- `clk`  in  1  system clock; only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  register select.
- `chipselect`  in  1  slave select.
- `read_n`  in  1  active-low read strobe.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  16  write data.
- `readdata`  out  16  registered read data; reset 0.
- `timer_tick`  in  1  timer `irq` level; each rising edge is one tick.
- `event_in`  in  1  asynchronous external event line.
- `irq`  out  1  interrupt; reset 0.

## Operation

- **Tick counter:** 32-bit `tick_count`, reset 0.
  - The rising edge of `timer_tick` is detected with a 1-flop delay. `tick_count` increments on the detect cycle.
  - Wraps from 0xFFFFFFFF to 0.
- **Event path:** `event_in` passes through a 2-flop synchronizer, then an optional filter, then a rising-edge detect.
  - When capture is enabled, the edge pushes the current `tick_count` (the pre-increment value if a tick occurs the same cycle) into the FIFO.
- **FIFO:** `FIFO_DEPTH` × 32 bits, with read and write pointers plus a level counter of 0..`FIFO_DEPTH`.
  - Push when full and no same-cycle pop: entry dropped, sticky `overflow` set.
  - Push and pop in the same cycle when full: both happen, no overflow.
  - Pop when empty: ignored.
- **Register map** (16-bit):
  - 0 STATUS: bit0 not_empty, bit1 full, bit2 overflow, bits[8:4] level. Any write clears overflow.
  - 1 CONTROL: bit0 irq_en, bit1 capture_en (R/W, reset 0).
    - bit2 flush: write-1 empties the FIFO and reads back 0.
    - bit3 clr_ticks: write-1 zeroes `tick_count` and reads back 0.
    - clr_ticks wins over a same-cycle tick increment.
  - 2 TICK_L: live `tick_count[15:0]`. The read also latches `tick_count[31:16]` into the `tick_shadow` register.
  - 3 TICK_H: `tick_shadow`.
  - 4 FIFO_L: head entry `[15:0]`, non-destructive.
  - 5 FIFO_H: head entry `[31:16]`. A read of this address pops the head.
  - 6, 7: read 0, writes ignored.
  - Reads of addresses 4/5 when empty return 0.
- **Interrupt:** `irq = irq_en && (not_empty || overflow)`, registered.
- **Flush priority:** a flush in the same cycle as a push leaves the FIFO empty; the push is discarded.

## Timing

- **Read latency:** 1 cycle. `readdata` is registered from the address sampled when `chipselect && !read_n`. Otherwise `readdata` holds its last value.
- **Pop side effects:** a pop from a read of address 5 takes effect at the end of the read cycle. A back-to-back read of address 4 sees the next entry.
- **Event latency:** `event_in` rising → push is 3 cycles unfiltered (2 sync + edge). Add `FILTER_LEN` cycles when the filter is compiled in.
- **Timer-tick latency:** `timer_tick` rising → `tick_count` updated after 2 cycles.
- **`irq` latency:** `irq` asserts 1 cycle after the level goes non-zero. It deasserts 1 cycle after the last pop when overflow is clear.
- **Capture gating:** events closer than 2 cycles apart (post-sync) merge into one capture. A pulse of at least 2 cycles high and 2 cycles low is guaranteed to capture.
- **Reset mid-operation:** all state returns to its reset value, FIFO contents are discarded, and no spurious push occurs on reset release even if `event_in` is high.

## Configuration

- `EVENT_CAPTURE_FILTER_EN`:
  - Defined: the synchronized `event_in` updates the filtered level only after `FILTER_LEN` consecutive identical samples. Shorter glitches are ignored.
  - Undefined: the filter is absent. The synchronized signal feeds the edge detect directly, and `FILTER_LEN` is unused.

## Test plan

- **Basic capture:** set capture_en, give 3 ticks, then one event. Read address 4 → 0x0003, then address 5 → 0x0000. STATUS then reads 0x0000.
- **Overflow:** depth 8 with capture enabled, 9 events without reads. STATUS = 0x0086 (level 8, full, overflow). FIFO order is preserved and the 9th event is dropped. A STATUS write clears overflow only.
- **Full push+pop:** with the FIFO full, align an event push with a read of address 5. Level stays 8, overflow stays 0, and the new entry lands at the tail.
- **Shadow and wrap:** preload `tick_count` to 0xFFFFFFFF via ticks/force in sim, read TICK_L, apply 1 tick, read TICK_H. Returns 0xFFFF (the shadow), and the live count is 0.
- **Interrupt:** with irq_en=1, an event asserts `irq` 1 cycle after the push. Popping the only entry deasserts `irq` 1 cycle later. Flush with a simultaneous event leaves level 0.
- **Filter (macro defined, `FILTER_LEN`=4):** a 3-cycle pulse on `event_in` produces no capture. A 6-cycle pulse produces exactly one capture.
